// File: rtl/brat_ckpt_ctrl.sv
// brat_ckpt_ctrl: branch RAT checkpoint tag allocator, in-order retire and mispredict recovery sequencer.
// Optional perf counters enabled by defining BRAT_CTRL_PERF_EN.
module brat_ckpt_ctrl #(
    parameter int NUM_BRATS       = 16,
    parameter int RECOVERY_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc_req,
    output logic                         alloc_gnt,
    output logic [$clog2(NUM_BRATS)-1:0] alloc_tag,
    input  logic                         resolve_valid,
    input  logic [$clog2(NUM_BRATS)-1:0] resolve_tag,
    input  logic                         resolve_mispredict,
    output logic                         recover_start,
    output logic [$clog2(NUM_BRATS)-1:0] recover_tag,
    output logic                         rename_stall,
    output logic [NUM_BRATS-1:0]         ckpt_busy,
    output logic [$clog2(NUM_BRATS):0]   num_outstanding,
    output logic                         full,
    output logic                         empty
`ifdef BRAT_CTRL_PERF_EN
    ,
    output logic [31:0]                  perf_allocs,
    output logic [31:0]                  perf_mispredicts,
    output logic [31:0]                  perf_stall_cycles
`endif
);
    localparam int W  = $clog2(NUM_BRATS);
    localparam int SW = RECOVERY_CYCLES > 1 ? $clog2(RECOVERY_CYCLES) : 1;

    typedef enum logic {IDLE, RECOVER} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   head_q, head_d, tail_q, tail_d, rtag_q, rtag_d;
    logic [W:0]     cnt_q, cnt_d;
    logic [NUM_BRATS-1:0] busy_q, busy_d;
    logic [SW-1:0]  stall_q, stall_d;
    logic           start_q, start_d;
    logic           mp, mp_acc, free, gnt;
    logic [W-1:0]   res_age, rtag_age;

    assign full            = cnt_q == (W+1)'(NUM_BRATS);
    assign empty           = cnt_q == '0;
    assign alloc_gnt       = gnt;
    assign alloc_tag       = tail_q;
    assign recover_start   = start_q;
    assign recover_tag     = rtag_q;
    assign rename_stall    = state_q == RECOVER;
    assign ckpt_busy       = busy_q;
    assign num_outstanding = cnt_q;

    always_comb begin
        mp       = resolve_valid & resolve_mispredict;
        res_age  = resolve_tag - head_q;
        rtag_age = rtag_q - head_q;
        // In RECOVER only a strictly older busy tag may redirect the recovery.
        mp_acc   = mp & busy_q[resolve_tag] & (state_q == IDLE || res_age < rtag_age);
        free     = (cnt_q != '0) & ~busy_q[head_q];
        gnt      = alloc_req & ~full & (state_q == IDLE) & ~mp;
        busy_d   = busy_q;
        if (resolve_valid && !resolve_mispredict)
            busy_d[resolve_tag] = 1'b0;
        for (int i = 0; i < NUM_BRATS; i++)
            if (mp_acc && W'(W'(i) - head_q) >= res_age)
                busy_d[i] = 1'b0;
        if (gnt)
            busy_d[tail_q] = 1'b1;
        head_d  = head_q + W'(free);
        tail_d  = mp_acc ? resolve_tag : tail_q + W'(gnt);
        cnt_d   = mp_acc ? {1'b0, res_age} - (W+1)'(free)
                         : cnt_q + (W+1)'(gnt) - (W+1)'(free);
        start_d = mp_acc;
        rtag_d  = mp_acc ? resolve_tag : rtag_q;
        state_d = mp_acc ? RECOVER : (state_q == RECOVER && stall_q == '0) ? IDLE : state_q;
        stall_d = mp_acc ? SW'(RECOVERY_CYCLES - 1)
                         : (state_q == RECOVER && stall_q != '0) ? stall_q - 1'b1 : stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= '0;
            stall_q <= '0;
            start_q <= 1'b0;
            rtag_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
            start_q <= start_d;
            rtag_q  <= rtag_d;
        end
    end

`ifdef BRAT_CTRL_PERF_EN
    logic [31:0] pa_q, pa_d, pm_q, pm_d, ps_q, ps_d;

    // Saturating event counters; they survive flush so software sees whole-run totals.
    always_comb begin
        pa_d = pa_q + 32'(gnt && pa_q != '1);
        pm_d = pm_q + 32'(mp_acc && pm_q != '1);
        ps_d = ps_q + 32'(rename_stall && ps_q != '1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pa_q <= '0;
            pm_q <= '0;
            ps_q <= '0;
        end else begin
            pa_q <= pa_d;
            pm_q <= pm_d;
            ps_q <= ps_d;
        end
    end

    assign perf_allocs       = pa_q;
    assign perf_mispredicts  = pm_q;
    assign perf_stall_cycles = ps_q;
`endif
endmodule

// File: doc/brat_ckpt_ctrl.md
Name: brat_ckpt_ctrl

Overview:
Checkpoint-slot manager for the branch RAT array in the OOO core.
- Allocates checkpoint tags to branches at rename, in program order.
- Tracks which tags are outstanding.
- Retires correctly predicted tags in order.
- On a mispredict, sequences recovery: frees the tag and all younger tags, rewinds allocation, and stalls rename while the RAT/free list are restored from the selected checkpoint.

Parameters:
- NUM_BRATS, 16, number of checkpoint slots; power of two, >= 2.
- RECOVERY_CYCLES, 2, cycles rename_stall stays asserted per recovery; >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; clears all state as rst does.
- alloc_req  in  1  rename has a branch needing a checkpoint this cycle.
- alloc_gnt  out  1  checkpoint granted; the snapshot is written this cycle.
- alloc_tag  out  $clog2(NUM_BRATS)  tag for the granted branch; equals tail.
- resolve_valid  in  1  a branch resolved this cycle.
- resolve_tag  in  $clog2(NUM_BRATS)  tag of the resolved branch.
- resolve_mispredict  in  1  the resolved branch mispredicted.
- recover_start  out  1  one-cycle pulse: restore from recover_tag.
- recover_tag  out  $clog2(NUM_BRATS)  checkpoint to restore; held until the next recovery.
- rename_stall  out  1  rename must hold.
- ckpt_busy  out  NUM_BRATS  bit i = tag i outstanding.
- num_outstanding  out  $clog2(NUM_BRATS)+1  count of allocated, not-yet-freed slots.
- full  out  1  num_outstanding == NUM_BRATS.
- empty  out  1  num_outstanding == 0.

Behaviour:
- State: circular head (oldest), tail (next allocation), num_outstanding, ckpt_busy, FSM {IDLE, RECOVER}, stall counter.
- Reset/flush values: head=tail=0, count=0, busy=0, FSM=IDLE, recover_start=0, recover_tag=0, rename_stall=0. flush has the same effect as rst, in any state including mid-RECOVER.
- Age: age(t) = (t - head) mod NUM_BRATS. Tag a is older than b iff age(a) < age(b).
- A tag is valid-resolvable iff its busy bit is 1. Resolves on non-busy tags are ignored (no state change).
- Grant rule (combinational): alloc_gnt = alloc_req & ~full & FSM==IDLE & ~(resolve_valid & resolve_mispredict).
  - On a grant: busy[tail]<=1, tail<=tail+1 (wraps), count+1.
- Correct resolve: busy[resolve_tag]<=0 next cycle.
- In-order free: each cycle, if count!=0 and busy[head]==0, then head<=head+1 and count-1. At most one free per cycle.
  - In the same cycle, a grant and a free leave count unchanged.
- Mispredict on busy tag T, FSM IDLE:
  - Next cycle: busy cleared for T and every younger outstanding tag; tail<=T; count<=age(T).
  - recover_start=1 for exactly one cycle; recover_tag=T; FSM->RECOVER.
  - rename_stall=1 for RECOVERY_CYCLES cycles starting the same cycle as recover_start.
  - FSM->IDLE after the last stall cycle.
- During RECOVER:
  - Correct resolves on busy tags are processed normally.
  - A mispredict on a busy tag older than the current recover_tag restarts recovery: new pulse, new tag, stall counter reloads.
  - Any other mispredict is ignored.
- Simultaneous correct resolve on tag A and mispredict: impossible (single resolve port).
- Simultaneous mispredict and alloc_req: the mispredict wins, no grant.
- Full: no grant; a resolve/free in the same cycle does not enable a grant until the next cycle.
- Empty with resolve: ignored (no busy bits).
- Wrap-around: all pointer arithmetic is modulo NUM_BRATS. count distinguishes full from empty when head==tail.

Optional Feature:
BRAT_CTRL_PERF_EN:
- Defined: adds outputs perf_allocs, perf_mispredicts, perf_stall_cycles, each 32 bits.
  - They count grants, accepted mispredicts, and rename_stall-high cycles.
  - They clear on rst only (not flush) and saturate at 2^32-1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then alloc_req held high for 16 cycles -> tags 0..15 granted, full=1 and count=16 after the 16th; the 17th request gets alloc_gnt=0.
- Allocate 0..3, then correct-resolve tags 2, 1, 0 on consecutive cycles -> head stays 0 until tag 0 clears, then advances 0→1→2→3 over three cycles; count 4→1.
- Allocate 0..5, mispredict tag 2 -> next cycle recover_start=1, recover_tag=2, busy=0b000011, tail=2, count=2; rename_stall high exactly 2 cycles; the next grant issues tag 2.
- Mispredict tag 4 with alloc_req high in the same cycle, then in RECOVER a mispredict on tag 1 -> first cycle alloc_gnt=0; the second recovery restarts with recover_tag=1, count=1, and the stall reloads to 2 cycles.
- Wrap: head=14 with tags 14, 15, 0, 1 outstanding; mispredict tag 15 -> tail=15, count=1, busy only bit 14; a mispredict on tag 3 (not busy) is ignored.
- flush asserted mid-RECOVER -> next cycle all outputs at reset values; with BRAT_CTRL_PERF_EN defined, the perf counters retain their values.
